serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 11 +
 rtl/serial_subtractor_fs.sv | 20 ++
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    // Bit counter width; the FSM leaves RUN at N-1, so $clog2(N) bits suffice.
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: two half-subtractors with their borrows OR-ed.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d, hs1_b;
    logic hs2_b;

    // First stage subtracts b from a; second subtracts the incoming borrow.
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;
    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: operands stream LSB-first through one
// full-subtractor cell with a registered borrow, one bit per clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         busy
);

    localparam int CW = cnt_w(N);

    sub_state_t    state, next_state;
    logic [N-1:0]  a_sh, b_sh, diff_q;
    logic          brw, bout_q;
    logic [CW-1:0] cnt;
    logic          cell_d, cell_b;
    logic          last_bit;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign last_bit = (cnt == CW'(N - 1));

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last_bit)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            brw    <= 1'b0;
            bout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        brw    <= bin;
                        cnt    <= '0;
                        diff_q <= '0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so bit 0 lands in place after N shifts.
                    diff_q <= {cell_d, diff_q[N-1:1]};
                    a_sh   <= {1'b0, a_sh[N-1:1]};
                    b_sh   <= {1'b0, b_sh[N-1:1]};
                    brw    <= cell_b;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) bout_q <= cell_b;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an N=8 instance for vectors,
// back-pressure and reset, plus an N=3 instance swept exhaustively.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, bin8 = 1'b0, bo8, busy8;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       iv3 = 1'b0, ir3, ov3, or3 = 1'b0, bin3 = 1'b0, bo3, busy3;
    logic [2:0] a3 = '0, b3 = '0, d3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .bin(bin8), .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .busy(busy8)
    );

    serial_subtractor #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
        .bin(bin3), .out_valid(ov3), .out_ready(or3), .diff(d3), .bout(bo3), .busy(busy3)
    );

    // Present one operation to dut8, wait for the result, hold it for
    // 'hold' cycles, then retire. Returns result and accept-to-valid edges.
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                       input int hold, output logic [7:0] dq, output logic bq, output int lat);
        a8 = ai; b8 = bi; bin8 = ci; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        dq = d8; bq = bo8;
        repeat (hold) begin @(posedge clk); #1; end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic op3(input logic [2:0] ai, input logic [2:0] bi, input logic ci,
                       input int hold, output logic [2:0] dq, output logic bq, output int lat);
        a3 = ai; b3 = bi; bin3 = ci; iv3 = 1'b1; or3 = 1'b0;
        @(posedge clk); #1;
        iv3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        dq = d3; bq = bo3;
        repeat (hold) begin @(posedge clk); #1; end
        or3 = 1'b1;
        @(posedge clk); #1;
        or3 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({ir8, ov8, busy8, bo8} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl8 got ir/ov/busy/bout=%b want 1000", {ir8, ov8, busy8, bo8});
        end
        checks++; if (d8 !== 8'h00) begin
            errors++; $display("FAIL reset_diff8 got %h want 00", d8);
        end
        checks++; if ({ir3, ov3, busy3, bo3, d3} !== 7'b1000_000) begin
            errors++; $display("FAIL reset_dut3 got %b want 1000000", {ir3, ov3, busy3, bo3, d3});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'h80};
        logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h00, 8'h7F};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] dq;
        logic       bq;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            op8(va[i], vb[i], vc[i], 0, dq, bq, lat);
            checks++; if (lat != 8) begin
                errors++; $display("FAIL vec%0d_latency got %0d want 8", i, lat);
            end
            checks++; if (dq !== ed[i]) begin
                errors++; $display("FAIL vec%0d_diff got %h want %h", i, dq, ed[i]);
            end
            checks++; if (bq !== eb[i]) begin
                errors++; $display("FAIL vec%0d_bout got %b want %b", i, bq, eb[i]);
            end
            checks++; if ({ir8, ov8, busy8} !== 3'b100) begin
                errors++; $display("FAIL vec%0d_retire got ir/ov/busy=%b want 100", i, {ir8, ov8, busy8});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] dq;
        logic       bq;
        int         lat;
        a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 8) begin
            errors++; $display("FAIL bp_latency got %0d want 8", lat);
        end
        // Keep offering new operands while the consumer stalls.
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; a8 = 8'(i * 37 + 1); b8 = 8'(i * 11 + 200);
            @(posedge clk); #1;
            checks++; if ({ov8, ir8, busy8, d8, bo8} !== {3'b101, 8'h27, 1'b0}) begin
                errors++; $display("FAIL bp_hold%0d got ov/ir/busy=%b diff=%h bout=%b want 101 27 0",
                                   i, {ov8, ir8, busy8}, d8, bo8);
            end
        end
        iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        checks++; if ({ov8, ir8, busy8} !== 3'b010) begin
            errors++; $display("FAIL bp_release got ov/ir/busy=%b want 010", {ov8, ir8, busy8});
        end
        op8(8'h10, 8'h01, 1'b0, 0, dq, bq, lat);
        checks++; if ({dq, bq} !== {8'h0F, 1'b0} || lat != 8) begin
            errors++; $display("FAIL bp_next got diff=%h bout=%b lat=%0d want 0f 0 8", dq, bq, lat);
        end
    endtask

    task automatic test_back_to_back();
        int         t0, t1, lat;
        logic [7:0] dq;
        logic       bq;
        // With out_ready and in_valid both high, accepts are N+2 edges apart.
        a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        t0 = -1; t1 = -1;
        for (int e = 0; e < 40 && t1 < 0; e++) begin
            if (ir8) begin
                if (t0 < 0) t0 = e; else t1 = e;
            end
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        checks++; if (t1 - t0 != 10 || t0 < 0) begin
            errors++; $display("FAIL b2b_interval got %0d want 10", t1 - t0);
        end
        lat = 0;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if ({d8, bo8} !== {8'hFF, 1'b1}) begin
            errors++; $display("FAIL b2b_result got diff=%h bout=%b want ff 1", d8, bo8);
        end
        @(posedge clk); #1;
        or8 = 1'b0;
        op8(8'hC8, 8'h64, 1'b0, 1, dq, bq, lat);
        checks++; if ({dq, bq} !== {8'h64, 1'b0}) begin
            errors++; $display("FAIL b2b_after got diff=%h bout=%b want 64 0", dq, bq);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] dq;
        logic       bq;
        int         lat;
        int         seen;
        a8 = 8'h03; b8 = 8'h05; bin8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if ({ir8, ov8, busy8, d8, bo8} !== {3'b100, 8'h00, 1'b0}) begin
            errors++; $display("FAIL midrst_state got ir/ov/busy=%b diff=%h bout=%b want 100 00 0",
                               {ir8, ov8, busy8}, d8, bo8);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov8) seen++;
        end
        checks++; if (seen != 0) begin
            errors++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen);
        end
        or8 = 1'b0;
        op8(8'h40, 8'h41, 1'b0, 2, dq, bq, lat);
        checks++; if ({dq, bq} !== {8'hFF, 1'b1} || lat != 8) begin
            errors++; $display("FAIL midrst_recover got diff=%h bout=%b lat=%0d want ff 1 8", dq, bq, lat);
        end
    endtask

    task automatic test_exhaustive3();
        logic [2:0] dq, ed;
        logic       bq, eb;
        int         lat;
        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    op3(3'(ia), 3'(ib), 1'(ic), int'($urandom_range(0, 3)), dq, bq, lat);
                    ed = 3'((ia - ib - ic) & 7);
                    eb = (ia < ib + ic);
                    checks++; if (dq !== ed || bq !== eb || lat != 3) begin
                        errors++;
                        $display("FAIL ex3 a=%0d b=%0d bin=%0d got diff=%0d bout=%b lat=%0d want %0d %b 3",
                                 ia, ib, ic, dq, bq, lat, ed, eb);
                    end
                end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_exhaustive3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
